// File: rtl/uart_packet_rx.sv
// ---------------------------------------------------------------------------
// uart_packet_rx
//   Packet parser that sits directly behind the UART receiver. It turns the
//   receiver's byte strobe into framed packets:
//     SYNC, destination, length, payload[length] (+ checksum, optional)
//   Payload bytes stream out as they arrive, tagged with start/end-of-packet.
//   A stalled packet is aborted by an inter-byte timeout. The UART cannot be
//   stalled, so there is no backpressure.
//
// Optional feature (macro UART_PACKET_CHECKSUM_EN):
//   A trailing checksum byte follows the payload (also when length is 0).
//   It must equal the modulo-256 sum of destination, length and payload.
//   A mismatch raises opError the cycle after the checksum byte.
//
// Parameters
//   SYNC_BYTE      start-of-packet marker, only recognised while idle
//   TIMEOUT_CLKS   max clocks between bytes inside a packet (>= 1)
//
// Ports
//   ipClk          system clock
//   ipnReset       asynchronous active-low reset
//   ipRxData       byte from the UART receiver
//   ipRxValid      one-cycle strobe qualifying ipRxData
//   opDestination  destination of the current packet, held until next header
//   opLength       payload length of the current packet, held until next header
//   opData         payload byte
//   opValid        one-cycle strobe qualifying opData
//   opSoP          with opValid: first payload byte
//   opEoP          with opValid: last payload byte
//   opError        one-cycle pulse: timeout abort or checksum failure
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | hunting for SYNC_BYTE, every other byte is dropped
// DEST  | next byte is the destination
// LEN   | next byte is the payload length
// DATA  | streaming payload bytes, byte counter holds bytes remaining
// CHECK | next byte is the checksum (checksum build only)
// ---------------------------------------------------------------------------
module uart_packet_rx #(
  parameter logic [7:0]  SYNC_BYTE    = 8'h55,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic       ipClk,
  input  logic       ipnReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output logic [7:0] opDestination,
  output logic [7:0] opLength,
  output logic [7:0] opData,
  output logic       opValid,
  output logic       opSoP,
  output logic       opEoP,
  output logic       opError
);

  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CLKS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEST  = 3'd1,
    S_LEN   = 3'd2,
`ifdef UART_PACKET_CHECKSUM_EN
    S_DATA  = 3'd3,
    S_CHECK = 3'd4
`else
    S_DATA  = 3'd3
`endif
  } state_e;

  // Where the FSM goes once the payload is complete.
`ifdef UART_PACKET_CHECKSUM_EN
  localparam state_e S_AFTER = S_CHECK;
`else
  localparam state_e S_AFTER = S_IDLE;
`endif

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    dest_q, dest_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          err_q, err_d;
  logic          timeout_hit;
`ifdef UART_PACKET_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state_q != S_IDLE) && !ipRxValid && (tmo_q == TMO_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    len_d   = len_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
`ifdef UART_PACKET_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    if ((state_q == S_IDLE) || ipRxValid || timeout_hit) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (ipRxValid && (ipRxData == SYNC_BYTE)) begin
          state_d = S_DEST;
        end
      end
      S_DEST: begin
        if (ipRxValid) begin
          dest_d  = ipRxData;
          state_d = S_LEN;
`ifdef UART_PACKET_CHECKSUM_EN
          sum_d   = ipRxData;
`endif
        end
      end
      S_LEN: begin
        if (ipRxValid) begin
          len_d   = ipRxData;
          cnt_d   = ipRxData;
          state_d = (ipRxData == 8'd0) ? S_AFTER : S_DATA;
`ifdef UART_PACKET_CHECKSUM_EN
          sum_d   = sum_q + ipRxData;
`endif
        end
      end
      S_DATA: begin
        if (ipRxValid) begin
          data_d  = ipRxData;
          valid_d = 1'b1;
          // cnt_q counts bytes still to come, so it equals len on the first.
          sop_d   = (cnt_q == len_q);
          eop_d   = (cnt_q == 8'd1);
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_AFTER;
          end
`ifdef UART_PACKET_CHECKSUM_EN
          sum_d   = sum_q + ipRxData;
`endif
        end
      end
`ifdef UART_PACKET_CHECKSUM_EN
      S_CHECK: begin
        if (ipRxValid) begin
          err_d   = (ipRxData != sum_q);
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: no EoP for a packet cut short, just the error pulse.
    if (timeout_hit) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      cnt_q   <= '0;
      dest_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_PACKET_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
`ifdef UART_PACKET_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign opDestination = dest_q;
  assign opLength      = len_q;
  assign opData        = data_q;
  assign opValid       = valid_q;
  assign opSoP         = sop_q;
  assign opEoP         = eop_q;
  assign opError       = err_q;

endmodule
